// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream TCDM reader: FSM state, controller-side
// control bundle and status flags.
package hwpe_stream_package;

  typedef enum logic [1:0] {
    IDLE,
    WORKING,
    DRAIN
  } tcdm_reader_state_t;

  typedef struct packed {
    logic        req_start;
    logic [31:0] base_addr;
    logic [31:0] stride;
    logic [31:0] trans_size;
  } ctrl_tcdm_reader_t;

  typedef struct packed {
    logic ready_start;
    logic done;
    logic in_progress;
  } flags_tcdm_reader_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_reader_fifo.sv
// Synchronous response buffer for TCDM read data; registered head, so a push
// becomes visible on the output one cycle later.
module hwpe_stream_tcdm_reader_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [31:0]   data_i,
  input  logic          pop_i,
  output logic [31:0]   data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign count_o = count_q;
  assign data_o  = mem[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i && !clear_i) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i) begin
      assert (!(push_i && full_o && !do_pop));
    end
  end

endmodule

// File: rtl/hwpe_stream_tcdm_reader.sv
// Strided TCDM word reader: issues reads under a credit limit and streams
// the returned words out through a response buffer.
module hwpe_stream_tcdm_reader
  import hwpe_stream_package::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [CNT_WIDTH-1:0] trans_size_i,
  output logic                 ready_start_o,
  output logic                 done_o,
  output logic                 in_progress_o,
  output logic                 tcdm_req_o,
  input  logic                 tcdm_gnt_i,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_data_o,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  output logic                 stream_valid_o,
  input  logic                 stream_ready_i,
  output logic [31:0]          stream_data_o,
  output logic [3:0]           stream_strb_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  ctrl_tcdm_reader_t  ctrl;
  flags_tcdm_reader_t flags;
  tcdm_reader_state_t state_q;

  logic [31:0]          addr_q;
  logic [31:0]          stride_q;
  logic [CNT_WIDTH-1:0] size_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 in_flight_q;
  logic                 done_q;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits;
  logic          req;
  logic          accept;
  logic          last_issue;
  logic          drain_done;

  always_comb begin
    ctrl.req_start  = start_i;
    ctrl.base_addr  = base_addr_i;
    ctrl.stride     = stride_i;
    ctrl.trans_size = 32'(trans_size_i);
  end

  // Credits cover buffered words plus the read whose data is still on its way;
  // while a request waits for gnt they can only shrink, so req stays asserted.
  assign credits    = {1'b0, fifo_count} + {{CW{1'b0}}, in_flight_q};
  assign req        = (state_q == WORKING) && (credits < (CW + 1)'(FIFO_DEPTH));
  assign accept     = req && tcdm_gnt_i;
  assign last_issue = (cnt_q == size_q - CNT_WIDTH'(1));

  // Data only counts when a read is actually outstanding, which also drops a
  // response arriving just after a clear.
  assign fifo_push  = tcdm_r_valid_i && in_flight_q;
  assign fifo_pop   = !fifo_empty && stream_ready_i;
  assign drain_done = !in_flight_q && (fifo_empty || (fifo_count == CW'(1) && fifo_pop));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      in_flight_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      in_flight_q <= accept;
      case (state_q)
        IDLE: begin
          if (ctrl.req_start) begin
            addr_q   <= ctrl.base_addr;
            stride_q <= ctrl.stride;
            size_q   <= ctrl.trans_size[CNT_WIDTH-1:0];
            cnt_q    <= '0;
            if (ctrl.trans_size == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= WORKING;
            end
          end
        end
        WORKING: begin
          if (accept) begin
            cnt_q  <= cnt_q + CNT_WIDTH'(1);
            addr_q <= addr_q + stride_q;
            if (last_issue) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  hwpe_stream_tcdm_reader_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(clear_i),
    .push_i (fifo_push),
    .data_i (tcdm_r_data_i),
    .pop_i  (fifo_pop),
    .data_o (stream_data_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    flags.ready_start = (state_q == IDLE);
    flags.done        = done_q;
    flags.in_progress = (state_q != IDLE);
  end

  assign ready_start_o  = flags.ready_start;
  assign done_o         = flags.done;
  assign in_progress_o  = flags.in_progress;

  assign tcdm_req_o     = req;
  assign tcdm_add_o     = word_align(addr_q);
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = 4'hF;
  assign tcdm_data_o    = '0;

  assign stream_valid_o = !fifo_empty;
  assign stream_strb_o  = 4'hF;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_hwpe_stream_tcdm_reader.sv
// Scoreboard bench for hwpe_stream_tcdm_reader: a TCDM slave model answers
// reads, expected addresses/words are queued at start and checked in order.
module tb_hwpe_stream_tcdm_reader;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_i, clear_i, start_i;
  logic [31:0] base_addr_i, stride_i;
  logic [15:0] trans_size_i;
  logic        ready_start_o, done_o, in_progress_o;
  logic        tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic [31:0] tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
  logic [3:0]  tcdm_be_o, stream_strb_o;
  logic        stream_valid_o, stream_ready_i;
  logic [31:0] stream_data_o;

  hwpe_stream_tcdm_reader #(
    .FIFO_DEPTH(DEPTH),
    .CNT_WIDTH (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .stride_i      (stride_i),
    .trans_size_i  (trans_size_i),
    .ready_start_o (ready_start_o),
    .done_o        (done_o),
    .in_progress_o (in_progress_o),
    .tcdm_req_o    (tcdm_req_o),
    .tcdm_gnt_i    (tcdm_gnt_i),
    .tcdm_add_o    (tcdm_add_o),
    .tcdm_wen_o    (tcdm_wen_o),
    .tcdm_be_o     (tcdm_be_o),
    .tcdm_data_o   (tcdm_data_o),
    .tcdm_r_data_i (tcdm_r_data_i),
    .tcdm_r_valid_i(tcdm_r_valid_i),
    .stream_valid_o(stream_valid_o),
    .stream_ready_i(stream_ready_i),
    .stream_data_o (stream_data_o),
    .stream_strb_o (stream_strb_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_cnt = 0, req_cnt = 0, done_cnt = 0, pop_cnt = 0;
  int last_gnt_cyc = 0, first_gnt_cyc = 0, done_cyc = 0;
  int gnt_limit = 1000000;
  bit gnt_en = 1'b1;
  bit arm_first = 1'b0;
  bit pend = 1'b0;
  logic [31:0] pend_data = '0;
  bit hold_prev = 1'b0;
  logic [31:0] held_data = '0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
  endfunction

  // TCDM slave: grant as allowed, respond exactly one cycle after each grant.
  initial begin
    tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0;
    forever begin
      @(posedge clk);
      #2;
      tcdm_r_valid_i = pend;
      tcdm_r_data_i  = pend ? pend_data : '0;
      pend = 1'b0;
      tcdm_gnt_i = gnt_en && (gnt_cnt < gnt_limit);
      @(negedge clk);
      if (tcdm_req_o) req_cnt++;
      if (tcdm_req_o && tcdm_gnt_i) begin
        gnt_cnt++;
        last_gnt_cyc = cyc;
        if (arm_first) begin first_gnt_cyc = cyc; arm_first = 1'b0; end
        pend = 1'b1;
        pend_data = mem_word(tcdm_add_o);
        check_eq("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) check_eq("req_addr", tcdm_add_o, exp_addr_q.pop_front());
      end
    end
  end

  // Stream sink and done monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (hold_prev) begin
        check_eq("hold_valid", 32'(stream_valid_o), 32'd1);
        check_eq("hold_data", stream_data_o, held_data);
      end
      hold_prev = stream_valid_o && !stream_ready_i;
      held_data = stream_data_o;
      if (stream_valid_o && stream_ready_i) begin
        pop_cnt++;
        check_eq("word_expected", 32'(exp_data_q.size() != 0), 32'd1);
        if (exp_data_q.size() != 0) check_eq("stream_word", stream_data_o, exp_data_q.pop_front());
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] size);
    logic [31:0] a;
    a = base;
    for (int unsigned i = 0; i < 32'(size); i++) begin
      exp_addr_q.push_back({a[31:2], 2'b00});
      exp_data_q.push_back(mem_word({a[31:2], 2'b00}));
      a = a + stride;
    end
    @(posedge clk);
    #1;
    check_eq("ready_start_before", 32'(ready_start_o), 32'd1);
    arm_first = 1'b1;
    start_i = 1'b1; base_addr_i = base; stride_i = stride; trans_size_i = size;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, "_words_left"}, 32'(exp_data_q.size()), 32'd0);
    check_eq({tag, "_addrs_left"}, 32'(exp_addr_q.size()), 32'd0);
    check_eq({tag, "_idle"}, 32'(ready_start_o), 32'd1);
  endtask

  initial begin
    int d0, g0, r0, p0, n;
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
    base_addr_i = '0; stride_i = '0; trans_size_i = '0;
    stream_ready_i = 1'b1;

    @(negedge clk);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_req", 32'(tcdm_req_o), 32'd0);
    check_eq("rst_valid", 32'(stream_valid_o), 32'd0);
    check_eq("rst_add", tcdm_add_o, 32'h0);
    check_eq("rst_ready_start", 32'(ready_start_o), 32'd1);
    check_eq("rst_in_progress", 32'(in_progress_o), 32'd0);
    check_eq("const_wen", 32'(tcdm_wen_o), 32'd1);
    check_eq("const_be", 32'(tcdm_be_o), 32'hF);
    check_eq("const_strb", 32'(stream_strb_o), 32'hF);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // 1: linear read
    d0 = done_cnt; g0 = gnt_cnt;
    start_xfer(32'h1000, 32'd4, 16'd4);
    wait_done("linear", d0, 100);
    check_eq("linear_gnts", 32'(gnt_cnt - g0), 32'd4);
    check_eq("linear_back_to_back", 32'(last_gnt_cyc - first_gnt_cyc), 32'd3);
    check_eq("linear_done_latency", 32'(done_cyc - last_gnt_cyc), 32'd3);

    // 2: back-pressure
    d0 = done_cnt; g0 = gnt_cnt; p0 = pop_cnt;
    stream_ready_i = 1'b0;
    start_xfer(32'h4000, 32'd8, 16'd16);
    repeat (20) @(posedge clk);
    #1;
    check_eq("bp_gnts", 32'(gnt_cnt - g0), 32'(DEPTH));
    check_eq("bp_req_low", 32'(tcdm_req_o), 32'd0);
    check_eq("bp_valid", 32'(stream_valid_o), 32'd1);
    stream_ready_i = 1'b1;
    wait_done("bp", d0, 300);
    check_eq("bp_words", 32'(pop_cnt - p0), 32'd16);

    // 3: grant stall
    d0 = done_cnt; p0 = pop_cnt;
    gnt_en = 1'b0;
    start_xfer(32'h2000, 32'd4, 16'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_req", 32'(tcdm_req_o), 32'd1);
      check_eq("stall_add", tcdm_add_o, 32'h2000);
      check_eq("stall_in_progress", 32'(in_progress_o), 32'd1);
    end
    @(posedge clk);
    #1;
    gnt_en = 1'b1;
    wait_done("stall", d0, 100);
    check_eq("stall_words", 32'(pop_cnt - p0), 32'd1);

    // 4: zero length
    d0 = done_cnt; r0 = req_cnt;
    start_xfer(32'h8000, 32'd4, 16'd0);
    check_eq("zero_ready_start", 32'(ready_start_o), 32'd1);
    wait_done("zero", d0, 20);
    check_eq("zero_no_req", 32'(req_cnt - r0), 32'd0);

    // 5: address wrap-around
    d0 = done_cnt;
    start_xfer(32'hFFFF_FFF8, 32'd4, 16'd4);
    wait_done("wrap", d0, 100);

    // 6: clear in the cycle of the third grant
    d0 = done_cnt; g0 = gnt_cnt;
    gnt_limit = gnt_cnt + 3;
    start_xfer(32'h3000, 32'd4, 16'd8);
    n = 0;
    while (gnt_cnt - g0 < 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("clr_two_gnts", 32'(gnt_cnt - g0), 32'd2);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    @(negedge clk);
    check_eq("clr_ready_start", 32'(ready_start_o), 32'd1);
    check_eq("clr_in_progress", 32'(in_progress_o), 32'd0);
    check_eq("clr_valid", 32'(stream_valid_o), 32'd0);
    check_eq("clr_req", 32'(tcdm_req_o), 32'd0);
    check_eq("clr_add", tcdm_add_o, 32'h0);
    check_eq("clr_trailing_rvalid", 32'(tcdm_r_valid_i), 32'd1);
    @(negedge clk);
    check_eq("clr_dropped", 32'(stream_valid_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("clr_gnts", 32'(gnt_cnt - g0), 32'd3);
    check_eq("clr_no_done", 32'(done_cnt - d0), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    gnt_limit = 1000000;

    d0 = done_cnt; p0 = pop_cnt;
    start_xfer(32'h5000, 32'd12, 16'd3);
    wait_done("after_clr", d0, 100);
    check_eq("after_clr_words", 32'(pop_cnt - p0), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
